rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
- Source A is the in-order pipeline writeback; source B is a long-latency unit such as load or divide.
- Keeps a pending-write scoreboard for B's destinations and raises read-hazard stalls for the decode stage.
- Sits between the writeback sources and the register file's wen/w_addr/w_data inputs.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles B may wait while valid before it takes priority. Legal range 1..15.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  source A write request
- a_ready  out  1  A accepted when a_valid&&a_ready
- a_rd  in  5  A destination register
- a_data  in  XLEN  A write data
- b_valid  in  1  source B write request
- b_ready  out  1  B accepted when b_valid&&b_ready
- b_rd  in  5  B destination register
- b_data  in  XLEN  B write data
- b_issue  in  1  B has launched an op that will write b_issue_rd
- b_issue_rd  in  5  destination of the issued B op
- b_issue_ready  out  1  high when pending[b_issue_rd]==0
- rs1  in  5  decode read address 1
- rs2  in  5  decode read address 2
- stall  out  1  rs1 or rs2 is pending (x0 is never pending)
- rf_wen  out  1  to register file wen
- rf_waddr  out  5  to register file w_addr
- rf_wdata  out  XLEN  to register file w_data

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - pending[31:0]=0, starve_cnt=0, force_b=0.
  - a_ready and b_ready evaluate combinationally from the reset state.
- Priority: force_b = (starve_cnt >= STARVE_LIMIT).
  - a_ready = !(force_b && b_valid).
  - b_ready = !a_valid || force_b.
  - At most one grant per cycle.
  - Ready does not depend on rf state; the block never back-pressures both sources at once.
- Output register:
  - A grant at edge N sets rf_wen=(rd!=0), rf_waddr=rd and rf_wdata=data for cycle N+1.
  - The register file commits at edge N+1.
  - No grant: rf_wen=0; rf_waddr and rf_wdata hold their previous values.
- Writes to x0: the handshake completes, rf_wen stays 0, and pending is unchanged.
- Starvation counter (saturating 4-bit):
  - b_valid && !b_ready: increment.
  - B grant: clear to 0.
  - b_valid==0: clear to 0.
- Scoreboard:
  - b_issue with b_issue_rd!=0 sets pending[b_issue_rd] at the edge.
  - A B grant clears pending[b_rd] at the grant edge, one cycle before rf_wen rises for that write.
  - Same-cycle set and clear of the same index: set wins (new issue).
  - b_issue while b_issue_ready==0 is a protocol error; pending stays 1.
- Stall is combinational: stall = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]).
  - After a B write is granted, stall drops one cycle before the register file holds the data. Decode must cover that cycle with the bypass feature or by reading one cycle later.
- Source A writes are not checked against pending; the pipeline guarantees ordering.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: adds outputs byp1_hit, byp2_hit (1 bit each) and byp1_data, byp2_data (XLEN each).
  - bypN_hit = rf_wen && rf_waddr==rsN && rsN!=0; byp data = rf_wdata.
  - stall additionally ignores a pending register whose B write is currently on the output register.
- Undefined: these ports do not exist, and stall is exactly as above.

Test Plan:
- Reset mid-write: rf_wen=1, then rst_n low for 1 cycle -> rf_wen=0 and pending=0 immediately, without waiting for clk.
- A only: a_valid=1, a_rd=5, a_data=0x1234 -> a_ready=1, and the next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234. Repeat with a_rd=0 -> handshake completes, rf_wen=0.
- Contention, STARVE_LIMIT=4: A and B valid continuously -> A granted 4 cycles, B granted on cycle 5, starve_cnt=0, then A resumes.
- Scoreboard: b_issue rd=7; rs1=7 -> stall=1. B later writes rd=7 -> stall=0 from the cycle after the grant edge, rf_waddr=7 in that same cycle.
- Set/clear collision: B grant for rd=9 while b_issue rd=9 in the same cycle -> pending[9]=1 afterwards, and b_issue_ready=0 for rd=9.
- With RF_WB_BYPASS_EN: B writes rd=3 with data 0xDEAD and rs2=3 -> in the rf_wen cycle, byp2_hit=1, byp2_data=0xDEAD, stall=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Two-source register-file writeback arbiter with a starvation
//            guard and a pending-write scoreboard for read-hazard stalls.
//            Optional decode bypass enabled by macro RF_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            b_issue,
    input  logic [4:0]      b_issue_rd,
    output logic            b_issue_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef RF_WB_BYPASS_EN
    ,
    output logic            byp1_hit,
    output logic            byp2_hit,
    output logic [XLEN-1:0] byp1_data,
    output logic [XLEN-1:0] byp2_data
`endif
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve_cnt;
    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;
    logic        w_force_b;
    logic        w_a_grant;
    logic        w_b_grant;
    logic        w_rs1_pend;
    logic        w_rs2_pend;

    assign w_force_b = (r_starve_cnt >= c_starve_limit);
    assign a_ready   = !(w_force_b && b_valid);
    assign b_ready   = !a_valid || w_force_b;
    assign w_a_grant = a_valid && a_ready;
    assign w_b_grant = b_valid && b_ready;

    // Saturating wait counter; any B grant or idle B resets the age.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!b_valid || w_b_grant) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != 4'hF) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Issue is applied after retire so a same-index collision leaves it set.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_b_grant && (b_rd != 5'd0)) begin
            w_pending_nxt[b_rd] = 1'b0;
        end
        if (b_issue && (b_issue_rd != 5'd0)) begin
            w_pending_nxt[b_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= 1'b0;
            if (w_a_grant) begin
                rf_wen   <= (a_rd != 5'd0);
                rf_waddr <= a_rd;
                rf_wdata <= a_data;
            end else if (w_b_grant) begin
                rf_wen   <= (b_rd != 5'd0);
                rf_waddr <= b_rd;
                rf_wdata <= b_data;
            end
        end
    end

    assign b_issue_ready = !r_pending[b_issue_rd];

`ifdef RF_WB_BYPASS_EN
    logic r_out_b;

    // Remembers whether the write currently on the output register came from B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_b <= 1'b0;
        end else if (w_a_grant || w_b_grant) begin
            r_out_b <= w_b_grant;
        end
    end

    assign byp1_hit  = rf_wen && (rf_waddr == rs1) && (rs1 != 5'd0);
    assign byp2_hit  = rf_wen && (rf_waddr == rs2) && (rs2 != 5'd0);
    assign byp1_data = rf_wdata;
    assign byp2_data = rf_wdata;

    assign w_rs1_pend = (rs1 != 5'd0) && r_pending[rs1] && !(byp1_hit && r_out_b);
    assign w_rs2_pend = (rs2 != 5'd0) && r_pending[rs2] && !(byp2_hit && r_out_b);
`else
    assign w_rs1_pend = (rs1 != 5'd0) && r_pending[rs1];
    assign w_rs2_pend = (rs2 != 5'd0) && r_pending[rs2];
`endif

    assign stall = w_rs1_pend || w_rs2_pend;

endmodule

`default_nettype wire
